// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receive front end: 16x-oversampled deserialiser feeding a small
//   show-ahead FIFO that the CPU-side register logic pops.
//
//   Optional build macro UART_RX_PARITY_EN:
//     defined   -> 8E1 framing; bytes with bad even parity are dropped and
//                  parity_err is raised.
//     undefined -> 8N1 framing; parity_err is tied to 0.
//
//   Ports
//     clk        system clock, rising edge
//     resetn     synchronous reset, active HIGH despite the name
//     rx         asynchronous serial input, idles high
//     rd_en      one-cycle pop strobe (ignored while empty)
//     clr_err    clears the sticky error flags
//     rd_data    head-of-FIFO byte (show-ahead)
//     rx_valid   FIFO not empty
//     rx_count   FIFO occupancy, 0..DEPTH
//     overrun    sticky: byte dropped because the FIFO was full
//     frame_err  sticky: stop bit sampled low
//     parity_err sticky: parity mismatch
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | line idle, waiting for a falling edge
// S_START   | half a bit time to the middle of the start bit
// S_DATA    | sampling 8 data bits, LSB first, one per bit time
// S_PARITY  | sampling the even-parity bit (parity build only)
// S_STOP    | sampling the stop bit; push on high, frame error on low
// S_WAIT_IDLE | line held low after a bad stop bit; wait for it to go high

module uart_rx_fifo #(
  parameter int CLK_DIV = 27,
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [7:0]        rd_data,
  output logic              rx_valid,
  output logic [ADDR_W:0]   rx_count,
  output logic              overrun,
  output logic              frame_err,
  output logic              parity_err
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser plus one extra stage for falling-edge detection
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;
  logic rx_d;
  logic rx_fall;

  always_ff @(posedge clk) begin
    if (resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign rx_fall = rx_d & ~rx_s;

  // ---------------------------------------------------------------------
  // Oversample tick: down-counter, one tick every CLK_DIV cycles
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  always_ff @(posedge clk) begin
    if (resetn) begin
      div_cnt <= DIV_LOAD;
    end else if (div_cnt == '0) begin
      div_cnt <= DIV_LOAD;
    end else begin
      div_cnt <= div_cnt - DIV_W'(1);
    end
  end

  assign tick = (div_cnt == '0);

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_t     state;
  state_t     state_nxt;
  logic [3:0] os_cnt;      // ticks remaining to the next mid-bit sample
  logic [2:0] bit_cnt;     // data bits remaining after the current one
  logic [7:0] shift_reg;
  logic       par_bad;
  logic       push_req;
  logic       mid;

  logic os_ld_half;
  logic os_ld_full;
  logic shift_en;
  logic bit_ld;
  logic push_set;
  logic frame_evt;
  logic parity_evt;

  assign mid = tick && (os_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    os_ld_half = 1'b0;
    os_ld_full = 1'b0;
    shift_en   = 1'b0;
    bit_ld     = 1'b0;
    push_set   = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_fall) begin
          state_nxt  = S_START;
          os_ld_half = 1'b1;
        end
      end
      S_START: begin
        if (mid) begin
          if (!rx_s) begin
            state_nxt  = S_DATA;
            os_ld_full = 1'b1;
            bit_ld     = 1'b1;
          end else begin
            state_nxt = S_IDLE;   // glitch: too short to be a start bit
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shift_en   = 1'b1;
          os_ld_full = 1'b1;
          if (bit_cnt == 3'd0) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          os_ld_full = 1'b1;
          parity_evt = (rx_s != ^shift_reg);
          state_nxt  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (mid) begin
          if (rx_s) begin
            push_set  = ~par_bad;
            state_nxt = S_IDLE;
          end else begin
            frame_evt = 1'b1;
            state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      os_cnt    <= 4'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      par_bad   <= 1'b0;
      push_req  <= 1'b0;
    end else begin
      push_req <= push_set;

      // Half a bit (8 ticks) to mid start bit, then a full bit (16 ticks).
      if (os_ld_half) begin
        os_cnt <= 4'd7;
      end else if (os_ld_full) begin
        os_cnt <= 4'd15;
      end else if (tick && (os_cnt != 4'd0)) begin
        os_cnt <= os_cnt - 4'd1;
      end

      if (bit_ld) begin
        bit_cnt <= 3'd7;
      end else if (shift_en && (bit_cnt != 3'd0)) begin
        bit_cnt <= bit_cnt - 3'd1;
      end

      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
      end

      if (bit_ld) begin
        par_bad <= 1'b0;
      end else if (parity_evt) begin
        par_bad <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO. shift_reg is stable for the cycle after the stop sample, so the
  // push writes it directly.
  // ---------------------------------------------------------------------
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              ovf_evt;

  assign rx_valid  = (rx_count != '0);
  assign fifo_full = (rx_count == CNT_FULL);
  assign pop       = rd_en & rx_valid;
  // A simultaneous pop frees the slot, so a full FIFO can still accept.
  assign push      = push_req & (~fifo_full | pop);
  assign ovf_evt   = push_req & fifo_full & ~pop;
  assign rd_data   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= shift_reg;
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10:   rx_count <= rx_count + (ADDR_W + 1)'(1);
        2'b01:   rx_count <= rx_count - (ADDR_W + 1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags; a new event wins over a coincident clear.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetn) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= ovf_evt   | (overrun   & ~clr_err);
      frame_err <= frame_evt | (frame_err & ~clr_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_evt | (parity_err & ~clr_err);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (CLK_DIV=4 -> 64 clk per bit, DEPTH=16).
module tb_uart_rx_fifo;

  localparam int CLK_DIV  = 4;
  localparam int DEPTH    = 16;
  localparam int ADDR_W   = 4;
  localparam int BIT_CLKS = 16 * CLK_DIV;

  logic            clk = 1'b0;
  logic            resetn;
  logic            rx;
  logic            rd_en;
  logic            clr_err;
  logic [7:0]      rd_data;
  logic            rx_valid;
  logic [ADDR_W:0] rx_count;
  logic            overrun;
  logic            frame_err;
  logic            parity_err;

  uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus three sticky flags.
  logic [7:0] mq[$];
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[7];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    step(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_v);
    rx = 1'b1;
    step(20);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop_v);
    logic bad_par;
    bad_par = 1'b0;
`ifdef UART_RX_PARITY_EN
    bad_par = par_flip;
    if (bad_par) m_perr = 1'b1;
`endif
    if (!stop_v) m_ferr = 1'b1;
    else if (!bad_par) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovr = 1'b1;
    end
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop_v);
    send_frame(d, stop_v);
    model_frame(d, stop_v);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "/count"}, 32'(rx_count), 32'(mq.size()));
    chk({tag, "/valid"}, 32'(rx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, "/head"}, 32'(rd_data), 32'(mq[0]));
    chk({tag, "/overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "/frame_err"}, 32'(frame_err), 32'(m_ferr));
    chk({tag, "/parity_err"}, 32'(parity_err), 32'(m_perr));
  endtask

  task automatic pop_model(input string tag);
    if (mq.size() != 0) begin
      chk({tag, "/pop_data"}, 32'(rd_data), 32'(mq[0]));
      void'(mq.pop_front());
    end
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk({tag, "/pop_count"}, 32'(rx_count), 32'(mq.size()));
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    m_perr = 1'b0;
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0};
    vecs[6] = '{8'h7E, 1'b0, 1'b0, 8'h00, 1'b1};

    rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0; resetn = 1'b1;
    step(3);
    resetn = 1'b0;

    // Reset state
    chk("reset/count", 32'(rx_count), 32'd0);
    chk("reset/valid", 32'(rx_valid), 32'd0);
    chk("reset/rd_data", 32'(rd_data), 32'd0);
    chk("reset/flags", 32'({overrun, frame_err, parity_err}), 32'd0);
    step(5);

    // Short low glitch on an idle line
    rx = 1'b0; step(2); rx = 1'b1;
    step(200);
    chk("glitch/count", 32'(rx_count), 32'd0);
    chk("glitch/flags", 32'({overrun, frame_err, parity_err}), 32'd0);

    // Table-driven single frames
    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].d, vecs[k].stop);
      chk($sformatf("vec%0d/valid", k), 32'(rx_valid), 32'(vecs[k].exp_valid));
      chk($sformatf("vec%0d/frame_err", k), 32'(frame_err), 32'(vecs[k].exp_ferr));
      if (vecs[k].exp_valid) begin
        chk($sformatf("vec%0d/data", k), 32'(rd_data), 32'(vecs[k].exp_data));
        chk($sformatf("vec%0d/count", k), 32'(rx_count), 32'd1);
        rd_en = 1'b1; step(1); rd_en = 1'b0;
        chk($sformatf("vec%0d/valid_after_pop", k), 32'(rx_valid), 32'd0);
        chk($sformatf("vec%0d/count_after_pop", k), 32'(rx_count), 32'd0);
      end
      if (vecs[k].exp_ferr) begin
        clear_errs();
        chk($sformatf("vec%0d/ferr_cleared", k), 32'(frame_err), 32'd0);
      end
    end

    // Frame error followed by a long break, then a good frame
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'((8'h3C >> i) & 8'h01));
`ifdef UART_RX_PARITY_EN
    drive_bit(^8'h3C);
`endif
    rx = 1'b0;
    step(BIT_CLKS + 200);
    chk("break/frame_err", 32'(frame_err), 32'd1);
    chk("break/count", 32'(rx_count), 32'd0);
    rx = 1'b1;
    step(20);
    send_frame(8'h55, 1'b1);
    chk("break/next_count", 32'(rx_count), 32'd1);
    chk("break/next_data", 32'(rd_data), 32'h55);
    clear_errs();
    chk("break/ferr_cleared", 32'(frame_err), 32'd0);
    rd_en = 1'b1; step(1); rd_en = 1'b0;
    rd_en = 1'b1; step(1); rd_en = 1'b0;   // pop on empty is ignored
    chk("empty_pop/count", 32'(rx_count), 32'd0);

    // Overflow: 17 bytes, no reads
    for (int i = 0; i <= 16; i++) rx_frame(8'(i), 1'b1);
    chk("ovf/count", 32'(rx_count), 32'd16);
    chk("ovf/overrun", 32'(overrun), 32'd1);
    compare_all("ovf");
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf/order%0d", i), 32'(rd_data), 32'(i));
      pop_model("ovf");
    end
    clear_errs();
    compare_all("ovf_drained");

    // Full FIFO, stop-bit accept coincides with a pop
    for (int i = 0; i < 16; i++) rx_frame(8'(8'h40 + i), 1'b1);
    compare_all("full");
    fork
      send_frame(8'hC3, 1'b1);
      begin : watch_push
        int n;
        logic [7:0] head;
        n = 0;
        while (dut.push_req !== 1'b1 && n < 12 * BIT_CLKS) begin
          step(1);
          n++;
        end
        chk("full/push_seen", 32'(n < 12 * BIT_CLKS), 32'd1);
        head = rd_data;
        rd_en = 1'b1; step(1); rd_en = 1'b0;
        chk("full/popped_head", 32'(head), 32'h40);
        chk("full/new_head", 32'(rd_data), 32'h41);
        chk("full/count", 32'(rx_count), 32'd16);
        chk("full/overrun", 32'(overrun), 32'd0);
      end
    join
    void'(mq.pop_front());
    mq.push_back(8'hC3);
    compare_all("full_after");
    while (mq.size() != 0) pop_model("full_drain");

    // Reset mid-DATA with bytes buffered and a sticky flag set
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    rx_frame(8'h33, 1'b1);
    rx_frame(8'h99, 1'b0);
    compare_all("pre_reset");
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b0;
    step(BIT_CLKS / 2);
    resetn = 1'b1;
    rx = 1'b1;
    step(1);
    chk("midreset/count", 32'(rx_count), 32'd0);
    chk("midreset/valid", 32'(rx_valid), 32'd0);
    chk("midreset/flags", 32'({overrun, frame_err, parity_err}), 32'd0);
    resetn = 1'b0;
    mq.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    step(2 * BIT_CLKS);
    rx_frame(8'h7E, 1'b1);
    chk("midreset/next_data", 32'(rd_data), 32'h7E);
    compare_all("midreset");
    pop_model("midreset");

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
    rx_frame(8'h03, 1'b1);
    chk("parity_ok/count", 32'(rx_count), 32'd1);
    chk("parity_ok/data", 32'(rd_data), 32'h03);
    compare_all("parity_ok");
    pop_model("parity_ok");
    par_flip = 1'b1;
    rx_frame(8'h03, 1'b1);
    chk("parity_bad/perr", 32'(parity_err), 32'd1);
    chk("parity_bad/count", 32'(rx_count), 32'd0);
    compare_all("parity_bad");
    par_flip = 1'b0;
    clear_errs();
`endif

    // Randomised frames with interleaved pops and clears
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d;
      logic       stop_v;
      d      = 8'($urandom);
      stop_v = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      par_flip = ($urandom_range(0, 7) == 0);
`endif
      rx_frame(d, stop_v);
      compare_all($sformatf("rnd%0d", it));
      repeat ($urandom_range(0, 2)) pop_model($sformatf("rnd%0d", it));
      if ($urandom_range(0, 4) == 0) begin
        clear_errs();
        compare_all($sformatf("rnd%0d_clr", it));
      end
    end
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
